// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Function : Shares one single-ported 64-bit memory between instruction fetch
//            and the data port. Data has priority, bounded by a starvation limit.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
   parameter int DEPTH      = 1024,
   parameter int AW         = 10,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [63:0]   if_addr,
   output logic          if_ack,
   output logic [63:0]   if_rdata,
   output logic          if_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [63:0]   d_addr,
   input  logic [63:0]   d_wdata,
   output logic          d_ack,
   output logic [63:0]   d_rdata,
   output logic          d_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [63:0]   mem_wdata,
   input  logic [63:0]   mem_rdata,
   output logic          busy
);
   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_is_d;
   logic [LW-1:0]   r_lat;
   logic [SW-1:0]   r_starve;
   logic            r_if_ack;
   logic            r_if_err;
   logic [63:0]     r_if_rdata;
   logic            r_d_ack;
   logic            r_d_err;
   logic [63:0]     r_d_rdata;
   logic            r_mem_en;
   logic            r_mem_we;
   logic [AW-1:0]   r_mem_addr;
   logic [63:0]     r_mem_wdata;

   logic            w_d_win;
   logic            w_d_inrange;
   logic            w_if_inrange;

   // Data wins a tie unless fetch has already lost STARVE_MAX times in a row.
   assign w_d_win      = d_req && (!if_req || (r_starve != SW'(STARVE_MAX)));
   assign w_d_inrange  = (d_addr  < 64'(DEPTH));
   assign w_if_inrange = (if_addr < 64'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_is_d      <= 1'b0;
         r_lat       <= '0;
         r_starve    <= '0;
         r_if_ack    <= 1'b0;
         r_if_err    <= 1'b0;
         r_if_rdata  <= '0;
         r_d_ack     <= 1'b0;
         r_d_err     <= 1'b0;
         r_d_rdata   <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_d_win) begin
                  r_is_d   <= 1'b1;
                  r_starve <= if_req ? (r_starve + SW'(1)) : '0;
                  if (w_d_inrange) begin
                     r_state     <= S_ISSUE;
                     r_mem_en    <= 1'b1;
                     r_mem_we    <= d_we;
                     r_mem_addr  <= d_addr[AW-1:0];
                     r_mem_wdata <= d_wdata;
                  end else begin
                     r_state <= S_RESP;
                     r_d_ack <= 1'b1;
                     r_d_err <= 1'b1;
                  end
               end else if (if_req) begin
                  r_is_d   <= 1'b0;
                  r_starve <= '0;
                  if (w_if_inrange) begin
                     r_state     <= S_ISSUE;
                     r_mem_en    <= 1'b1;
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= if_addr[AW-1:0];
                     r_mem_wdata <= '0;
                  end else begin
                     r_state  <= S_RESP;
                     r_if_ack <= 1'b1;
                     r_if_err <= 1'b1;
                  end
               end else begin
                  r_starve <= '0;
               end
            end

            S_ISSUE: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               if (r_mem_we) begin
                  r_state  <= S_RESP;
                  r_d_ack  <= r_is_d;
                  r_if_ack <= !r_is_d;
               end else begin
                  r_state <= S_WAIT;
                  r_lat   <= '0;
               end
            end

            S_WAIT: begin
               if (r_lat == LW'(MEM_LAT - 1)) begin
                  r_state <= S_RESP;
                  if (r_is_d) begin
                     r_d_ack   <= 1'b1;
                     r_d_rdata <= mem_rdata;
                  end else begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= mem_rdata;
                  end
               end else begin
                  r_lat <= r_lat + LW'(1);
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_if_ack   <= 1'b0;
               r_if_err   <= 1'b0;
               r_if_rdata <= '0;
               r_d_ack    <= 1'b0;
               r_d_err    <= 1'b0;
               r_d_rdata  <= '0;
            end
         endcase
      end
   end

   assign if_ack    = r_if_ack;
   assign if_err    = r_if_err;
   assign if_rdata  = r_if_rdata;
   assign d_ack     = r_d_ack;
   assign d_err     = r_d_err;
   assign d_rdata   = r_d_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
